battlefront_calc: RTL and testbench

BATTLEFRONT_CALC -- requirements
Module: battlefront_calc

---
 rtl/battle_pkg.sv | 24 ++
 rtl/tick_divider.sv | 30 +++
 rtl/battlefront_calc.sv | 150 +++++++++++++++
 tb/tb_battlefront_calc.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared widths, sentinels, FSM encoding and helpers for the battlefront calculator.
package battle_pkg;

  localparam int POS_W = 9;
  localparam int DMG_W = 8;

  localparam logic [POS_W-1:0] NO_FRONT = 9'h1FF;
  localparam logic [DMG_W-1:0] DMG_MAX  = 8'hFF;

  // FSM encoding kept as plain constants for compatibility with existing code.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_DAMAGE = 2'd2;
  localparam logic [1:0] ST_MOVE   = 2'd3;

  // Damage addition that clamps at DMG_MAX instead of wrapping.
  function automatic logic [DMG_W-1:0] sat_add(input logic [DMG_W-1:0] a,
                                               input logic [DMG_W-1:0] b);
    logic [DMG_W:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    return wide[DMG_W] ? DMG_MAX : wide[DMG_W-1:0];
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Round pacing counter: counts enabled cycles and flags the last one of a period.
module tick_divider #(
  parameter int TICK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count while enabled; clear has priority so the next period starts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/battlefront_calc.sv
// Battle round sequencer: waits TICK_DIV idle cycles, scans player slots one per
// cycle for the frontmost alive unit and summed attack, then issues one damage
// and one move strobe. All outputs are registered one cycle behind the FSM state.
module battlefront_calc
  import battle_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int TICK_DIV  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [9*NUM_UNITS-1:0]     playerPos,
  input  logic [NUM_UNITS-1:0]       playerAlive,
  input  logic [8*NUM_UNITS-1:0]     playerDmgOut,
  input  logic [8:0]                 enemyPos,
  input  logic [7:0]                 enemyDmgOut,
  input  logic [1:0]                 enemyType,
  output logic                       enemyMoveSCEN,
  output logic                       enemyDamageSCEN,
  output logic [7:0]                 enemyDamageIn,
  output logic [8:0]                 enemyUnitFront,
  output logic                       playerMoveSCEN,
  output logic                       playerDamageSCEN,
  output logic [8*NUM_UNITS-1:0]     playerDamageIn,
  output logic [8:0]                 playerUnitFront
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  scan_idx;
  logic [POS_W-1:0]  best_pos, best_pos_nxt;
  logic [IDX_W-1:0]  best_idx, best_idx_nxt;
  logic              best_valid, best_valid_nxt;
  logic [DMG_W-1:0]  dmg_sum, dmg_sum_nxt;
  logic [POS_W-1:0]  slot_pos;
  logic [DMG_W-1:0]  slot_dmg;
  logic              slot_alive;
  logic              enemy_alive;
  logic              scan_last;
  logic              div_en, div_clr, tick;
  logic [DMG_W*NUM_UNITS-1:0] player_dmg_nxt;

  assign enemy_alive = (enemyType != 2'd0);
  assign scan_last   = (state == ST_SCAN) && (scan_idx == LAST_IDX);
  assign div_en      = enable && (state == ST_IDLE);
  assign div_clr     = div_en && tick;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (div_en),
    .clear  (div_clr),
    .tick   (tick)
  );

  // Fold the currently indexed slot into the running front/sum; strict '<' keeps the lowest index on ties.
  always_comb begin
    slot_pos       = playerPos[int'(scan_idx)*POS_W +: POS_W];
    slot_dmg       = playerDmgOut[int'(scan_idx)*DMG_W +: DMG_W];
    slot_alive     = playerAlive[scan_idx];
    best_pos_nxt   = best_pos;
    best_idx_nxt   = best_idx;
    best_valid_nxt = best_valid;
    dmg_sum_nxt    = dmg_sum;
    if (slot_alive) begin
      if (!best_valid || (slot_pos < best_pos)) begin
        best_pos_nxt   = slot_pos;
        best_idx_nxt   = scan_idx;
        best_valid_nxt = 1'b1;
      end
      dmg_sum_nxt = sat_add(dmg_sum, slot_dmg);
    end
  end

  // Per-slot damage: only the frontmost valid slot is hit, and only by a live enemy.
  always_comb begin
    player_dmg_nxt = '0;
    if ((state == ST_DAMAGE) && enemy_alive && best_valid) begin
      player_dmg_nxt[int'(best_idx)*DMG_W +: DMG_W] = enemyDmgOut;
    end
  end

  // Round sequencing and scan accumulators; a round in flight always runs to MOVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      scan_idx   <= '0;
      best_pos   <= NO_FRONT;
      best_idx   <= '0;
      best_valid <= 1'b0;
      dmg_sum    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_clr) begin
            state      <= ST_SCAN;
            scan_idx   <= '0;
            best_pos   <= NO_FRONT;
            best_idx   <= '0;
            best_valid <= 1'b0;
            dmg_sum    <= '0;
          end
        end
        ST_SCAN: begin
          best_pos   <= best_pos_nxt;
          best_idx   <= best_idx_nxt;
          best_valid <= best_valid_nxt;
          dmg_sum    <= dmg_sum_nxt;
          scan_idx   <= scan_idx + 1'b1;
          if (scan_idx == LAST_IDX) begin
            state <= ST_DAMAGE;
          end
        end
        ST_DAMAGE: state <= ST_MOVE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Registered outputs: strobes and damage follow the state, fronts latch as the scan completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enemyMoveSCEN    <= 1'b0;
      enemyDamageSCEN  <= 1'b0;
      enemyDamageIn    <= '0;
      enemyUnitFront   <= NO_FRONT;
      playerMoveSCEN   <= 1'b0;
      playerDamageSCEN <= 1'b0;
      playerDamageIn   <= '0;
      playerUnitFront  <= '0;
    end else begin
      enemyDamageSCEN  <= (state == ST_DAMAGE);
      playerDamageSCEN <= (state == ST_DAMAGE);
      enemyMoveSCEN    <= (state == ST_MOVE);
      playerMoveSCEN   <= (state == ST_MOVE);
      enemyDamageIn    <= ((state == ST_DAMAGE) && enemy_alive) ? dmg_sum : '0;
      playerDamageIn   <= player_dmg_nxt;
      if (scan_last) begin
        enemyUnitFront  <= best_valid_nxt ? best_pos_nxt : NO_FRONT;
        playerUnitFront <= enemy_alive ? enemyPos : '0;
      end
    end
  end

endmodule

// File: tb/tb_battlefront_calc.sv
// Self-checking bench for battlefront_calc (NUM_UNITS=4, TICK_DIV=8).
module tb_battlefront_calc;

  localparam int NU = 4;
  localparam int TD = 8;
  localparam int PERIOD = TD + NU + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [8:0] pos [NU];
  logic [7:0] dmg [NU];
  logic       alive [NU];
  logic [8:0] e_pos = '0;
  logic [7:0] e_dmg = '0;
  logic [1:0] e_type = '0;

  logic [9*NU-1:0] playerPos;
  logic [NU-1:0]   playerAlive;
  logic [8*NU-1:0] playerDmgOut;
  logic enemyMoveSCEN, enemyDamageSCEN, playerMoveSCEN, playerDamageSCEN;
  logic [7:0] enemyDamageIn;
  logic [8:0] enemyUnitFront, playerUnitFront;
  logic [8*NU-1:0] playerDamageIn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NU; i++) begin
      playerPos[9*i +: 9]    = pos[i];
      playerDmgOut[8*i +: 8] = dmg[i];
      playerAlive[i]         = alive[i];
    end
  end

  battlefront_calc #(.NUM_UNITS(NU), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .playerPos(playerPos), .playerAlive(playerAlive), .playerDmgOut(playerDmgOut),
    .enemyPos(e_pos), .enemyDmgOut(e_dmg), .enemyType(e_type),
    .enemyMoveSCEN(enemyMoveSCEN), .enemyDamageSCEN(enemyDamageSCEN),
    .enemyDamageIn(enemyDamageIn), .enemyUnitFront(enemyUnitFront),
    .playerMoveSCEN(playerMoveSCEN), .playerDamageSCEN(playerDamageSCEN),
    .playerDamageIn(playerDamageIn), .playerUnitFront(playerUnitFront)
  );

  // Reference: what one round should report, from the battle rules directly.
  function automatic void model(output logic [8:0] ef, output logic [8*NU-1:0] pd,
                                output logic [7:0] ed, output logic [8:0] pf);
    int best = -1;
    int s = 0;
    for (int i = 0; i < NU; i++) begin
      if (alive[i]) begin
        s += int'(dmg[i]);
        if (best < 0 || pos[i] < pos[best]) best = i;
      end
    end
    ed = (e_type == 0) ? 8'h00 : ((s > 255) ? 8'hFF : 8'(s));
    ef = (best < 0) ? 9'h1FF : pos[best];
    pd = '0;
    if (e_type != 0 && best >= 0) pd[8*best +: 8] = e_dmg;
    pf = (e_type != 0) ? e_pos : 9'h000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_strobe(input int limit, output int cycles, output bit found);
    cycles = 0;
    found = 1'b0;
    while (!found && cycles < limit) begin
      step();
      cycles++;
      if (enemyDamageSCEN) found = 1'b1;
    end
  endtask

  task automatic set_units(input logic [8:0] p0, p1, p2, p3,
                           input logic [7:0] d0, d1, d2, d3,
                           input logic [3:0] al);
    pos[0] = p0; pos[1] = p1; pos[2] = p2; pos[3] = p3;
    dmg[0] = d0; dmg[1] = d1; dmg[2] = d2; dmg[3] = d3;
    for (int i = 0; i < NU; i++) alive[i] = al[i];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    step(); step();
    checks++;
    if ({enemyMoveSCEN, enemyDamageSCEN, playerMoveSCEN, playerDamageSCEN} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000",
               {enemyMoveSCEN, enemyDamageSCEN, playerMoveSCEN, playerDamageSCEN});
    end
    checks++;
    if (enemyDamageIn !== 8'h00 || playerDamageIn !== '0) begin
      errors++;
      $display("FAIL reset_damage: got e=%h p=%h expected 0", enemyDamageIn, playerDamageIn);
    end
    checks++;
    if (enemyUnitFront !== 9'h1FF) begin
      errors++;
      $display("FAIL reset_enemy_front: got %h expected 1ff", enemyUnitFront);
    end
    checks++;
    if (playerUnitFront !== 9'h000) begin
      errors++;
      $display("FAIL reset_player_front: got %h expected 000", playerUnitFront);
    end
  endtask

  task automatic test_no_units();
    int cyc;
    bit ok;
    set_units(9'd10, 9'd20, 9'd30, 9'd40, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
    e_type = 2'd1; e_dmg = 8'h33; e_pos = 9'd77;
    enable = 1'b1;
    pulse_reset();
    wait_strobe(40, cyc, ok);
    checks++;
    if (!ok || cyc != PERIOD - 1) begin
      errors++;
      $display("FAIL no_units_first_strobe: got ok=%0d cycles=%0d expected cycles=%0d", ok, cyc, PERIOD - 1);
    end
    checks++;
    if (playerDamageSCEN !== 1'b1 || enemyMoveSCEN !== 1'b0) begin
      errors++;
      $display("FAIL no_units_strobe_pair: got pd=%b em=%b expected 1 0", playerDamageSCEN, enemyMoveSCEN);
    end
    checks++;
    if (enemyUnitFront !== 9'h1FF || enemyDamageIn !== 8'h00 || playerDamageIn !== '0) begin
      errors++;
      $display("FAIL no_units_values: got front=%h ed=%h pd=%h expected 1ff 00 0",
               enemyUnitFront, enemyDamageIn, playerDamageIn);
    end
    step();
    checks++;
    if ({enemyMoveSCEN, playerMoveSCEN, enemyDamageSCEN, playerDamageSCEN} !== 4'b1100) begin
      errors++;
      $display("FAIL no_units_move: got %b expected 1100",
               {enemyMoveSCEN, playerMoveSCEN, enemyDamageSCEN, playerDamageSCEN});
    end
    wait_strobe(40, cyc, ok);
    checks++;
    if (!ok || cyc != PERIOD - 1) begin
      errors++;
      $display("FAIL no_units_period: got ok=%0d cycles=%0d expected %0d after move", ok, cyc, PERIOD - 1);
    end
  endtask

  task automatic test_front_tie();
    int cyc;
    bit ok;
    set_units(9'd200, 9'd150, 9'd150, 9'd300, 8'h01, 8'h02, 8'h03, 8'h04, 4'b1111);
    e_type = 2'd1; e_dmg = 8'h20; e_pos = 9'd123;
    pulse_reset();
    wait_strobe(40, cyc, ok);
    checks++;
    if (!ok || playerDamageIn !== 32'h0000_2000) begin
      errors++;
      $display("FAIL tie_player_damage: got ok=%0d %h expected 00002000", ok, playerDamageIn);
    end
    checks++;
    if (enemyUnitFront !== 9'd150 || playerUnitFront !== 9'd123) begin
      errors++;
      $display("FAIL tie_fronts: got ef=%0d pf=%0d expected 150 123", enemyUnitFront, playerUnitFront);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    bit ok;
    set_units(9'd50, 9'd60, 9'd70, 9'd80, 8'h80, 8'h90, 8'h10, 8'h05, 4'b1111);
    e_type = 2'd2; e_dmg = 8'h07; e_pos = 9'd5;
    pulse_reset();
    wait_strobe(40, cyc, ok);
    checks++;
    if (!ok || enemyDamageIn !== 8'hFF) begin
      errors++;
      $display("FAIL sat_full: got ok=%0d %h expected ff", ok, enemyDamageIn);
    end
    alive[1] = 1'b0;
    wait_strobe(40, cyc, ok);
    checks++;
    if (!ok || enemyDamageIn !== 8'h95) begin
      errors++;
      $display("FAIL sat_slot1_dead: got ok=%0d %h expected 95", ok, enemyDamageIn);
    end
  endtask

  task automatic test_enemy_dead();
    int cyc;
    bit ok;
    set_units(9'd9, 9'd8, 9'd7, 9'd6, 8'h10, 8'h10, 8'h10, 8'h10, 4'b1111);
    e_type = 2'd0; e_dmg = 8'h40; e_pos = 9'd99;
    pulse_reset();
    wait_strobe(40, cyc, ok);
    checks++;
    if (!ok || playerDamageIn !== '0 || enemyDamageIn !== 8'h00) begin
      errors++;
      $display("FAIL dead_damage: got ok=%0d pd=%h ed=%h expected 0 0", ok, playerDamageIn, enemyDamageIn);
    end
    checks++;
    if (playerUnitFront !== 9'h000 || enemyUnitFront !== 9'd6) begin
      errors++;
      $display("FAIL dead_fronts: got pf=%h ef=%0d expected 000 6", playerUnitFront, enemyUnitFront);
    end
  endtask

  task automatic test_random();
    logic [8:0] ef, pf;
    logic [8*NU-1:0] pd;
    logic [7:0] ed;
    bit ok;
    int cyc;
    pulse_reset();
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NU; i++) begin
        pos[i]   = 9'($urandom_range(0, 511));
        dmg[i]   = 8'($urandom);
        alive[i] = 1'($urandom);
      end
      if (r % 4 == 0) pos[3] = pos[1];
      e_type = 2'($urandom);
      e_dmg  = 8'($urandom);
      e_pos  = 9'($urandom);
      model(ef, pd, ed, pf);
      ok = 1'b0;
      cyc = 0;
      while (!ok && cyc < 40) begin
        step();
        cyc++;
        if (enemyDamageSCEN) ok = 1'b1;
        else begin
          checks++;
          if (enemyDamageIn !== 8'h00 || playerDamageIn !== '0) begin
            errors++;
            $display("FAIL rand_idle_damage r%0d: got ed=%h pd=%h expected 0", r, enemyDamageIn, playerDamageIn);
          end
        end
      end
      checks++;
      if (!ok || enemyDamageIn !== ed || playerDamageIn !== pd) begin
        errors++;
        $display("FAIL rand_damage r%0d: got ok=%0d ed=%h pd=%h expected ed=%h pd=%h",
                 r, ok, enemyDamageIn, playerDamageIn, ed, pd);
      end
      checks++;
      if (enemyUnitFront !== ef || playerUnitFront !== pf) begin
        errors++;
        $display("FAIL rand_fronts r%0d: got ef=%h pf=%h expected ef=%h pf=%h",
                 r, enemyUnitFront, playerUnitFront, ef, pf);
      end
    end
  endtask

  task automatic test_reset_mid_round();
    int cyc;
    bit ok;
    set_units(9'd40, 9'd30, 9'd20, 9'd10, 8'h01, 8'h01, 8'h01, 8'h01, 4'b1111);
    e_type = 2'd3; e_dmg = 8'h05; e_pos = 9'd44;
    pulse_reset();
    wait_strobe(40, cyc, ok);
    for (int i = 0; i < 11; i++) step();
    reset = 1'b1;
    #1;
    checks++;
    if (enemyUnitFront !== 9'h1FF || playerUnitFront !== 9'h000 ||
        {enemyMoveSCEN, enemyDamageSCEN, playerMoveSCEN, playerDamageSCEN} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got ef=%h pf=%h strobes=%b expected 1ff 000 0000",
               enemyUnitFront, playerUnitFront,
               {enemyMoveSCEN, enemyDamageSCEN, playerMoveSCEN, playerDamageSCEN});
    end
    step();
    reset = 1'b0;
    wait_strobe(40, cyc, ok);
    step();
    checks++;
    if (!ok || cyc != PERIOD - 1 || enemyMoveSCEN !== 1'b1) begin
      errors++;
      $display("FAIL midreset_restart: got ok=%0d damage_at=%0d move=%b expected %0d 1",
               ok, cyc, enemyMoveSCEN, PERIOD - 1);
    end
  endtask

  task automatic test_enable_drop();
    int cyc;
    int seen;
    bit ok;
    enable = 1'b1;
    pulse_reset();
    wait_strobe(40, cyc, ok);
    for (int i = 0; i < 10; i++) step();
    enable = 1'b0;
    wait_strobe(40, cyc, ok);
    checks++;
    if (!ok || cyc != 4) begin
      errors++;
      $display("FAIL drop_round_completes: got ok=%0d cycles=%0d expected 4", ok, cyc);
    end
    step();
    checks++;
    if (playerMoveSCEN !== 1'b1) begin
      errors++;
      $display("FAIL drop_move: got %b expected 1", playerMoveSCEN);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (enemyDamageSCEN || enemyMoveSCEN || playerDamageSCEN || playerMoveSCEN) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL drop_quiet: got %0d strobe cycles expected 0", seen);
    end
    // Pause enable for 5 cycles mid-IDLE: the counter must hold, stretching the round.
    enable = 1'b1;
    wait_strobe(40, cyc, ok);
    for (int i = 0; i < 4; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    enable = 1'b1;
    wait_strobe(40, cyc, ok);
    checks++;
    if (!ok || cyc != 10) begin
      errors++;
      $display("FAIL idle_hold: got ok=%0d cycles=%0d expected 10", ok, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < NU; i++) begin
      pos[i] = '0; dmg[i] = '0; alive[i] = 1'b0;
    end
    test_reset();
    test_no_units();
    test_front_tie();
    test_saturation();
    test_enemy_dead();
    test_random();
    test_reset_mid_round();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
